cal_lable_render_ctrl: RTL and testbench
========================================

// Module: cal_lable_render_ctrl
// PURPOSE
//  Renders one calendar day label (MON..SUN) from the days-label pixel path into the frame buffer.
//  On start it latches the label position, scans a WIN_X x WIN_Y window and drives x/y/pos into the label-to-pixel block.
//  Returned pixels pass through a credit-limited buffer to a valid/ready frame-buffer write port.
//  Used by the calendar draw sequencer to redraw labels.
// PARAMETERS
//  WIN_X     132             scan width in px; covers 1 px left offset + 130 px label + 1 px right border
//  WIN_Y     30              scan height in px (label height)
//  PIX_X_W   12              x coordinate width
//  PIX_Y_W   12              y coordinate width
//  RD_LAT    1               cycles from lbl_x_o/lbl_y_o/lbl_pos_o to valid lbl_pix_i (ROM read latency)
//  FB_AW     19              frame-buffer address width
//  FB_STRIDE 640             frame-buffer pixels per line
//  POS_W     $clog2(`CAL_POS_CNT)  label position index width
// PORTS
//  clk_i      in   1         clock
//  rst_i      in   1         asynchronous reset, active-low
//  start_i    in   1         single-cycle start request
//  pos_i      in   POS_W     label to draw; sampled with start_i
//  fb_base_i  in   FB_AW     frame-buffer address of window pixel (0,0); sampled with start_i
//  busy_o     out  1         high from accepted start until last write accepted
//  done_o     out  1         one-cycle pulse after last write accepted
//  lbl_pos_o  out  POS_W     to label pixel block: cur_pos
//  lbl_x_o    out  PIX_X_W   to label pixel block: pos_x
//  lbl_y_o    out  PIX_Y_W   to label pixel block: pos_y
//  lbl_pix_i  in   1         pixel from label pixel block, RD_LAT cycles after its x/y
//  wr_valid_o out  1         frame-buffer write valid
//  wr_ready_i in   1         frame-buffer write ready
//  wr_addr_o  out  FB_AW     fb_base + y*FB_STRIDE + x, modulo 2**FB_AW
//  wr_data_o  out  1         pixel value
// BEHAVIOUR
//  Reset values: busy_o, done_o and wr_valid_o are 0; lbl_*, wr_addr_o and wr_data_o are 0; FSM is in IDLE.
//  FSM states:
//   IDLE -> SCAN on start_i.
//   SCAN: issues one coordinate per cycle; issue is gated by credit.
//   SCAN -> DRAIN after the issue of (WIN_X-1, WIN_Y-1).
//   DRAIN -> DONE when the buffer is empty, nothing is in flight and the last beat is accepted.
//   DONE -> IDLE after 1 cycle with done_o=1.
//  Scan order is raster: x 0..WIN_X-1, then y++. x wraps to 0 on y increment.
//  Credit rule: issue only if (buffer occupancy + in-flight) < RD_LAT+1. The buffer has RD_LAT+1 entries.
//  A delay line of RD_LAT stages carries {valid, addr} alongside each ROM read.
//  A pixel that returns is always pushed; it is never dropped.
//  wr_valid_o = buffer not empty. A pop occurs on wr_valid_o & wr_ready_i.
//  While wr_valid_o is high and wr_ready_i is low, wr_addr_o and wr_data_o are held stable.
//  Zero-bubble operation: with wr_ready_i tied high, one write is accepted per cycle. First write occurs RD_LAT+1 cycles after start.
//  start_i while busy_o=1 is ignored; no re-latch.
//  lbl_pos_o is held at the latched pos for the whole job; other outputs hold their last value in IDLE.
//  Address arithmetic is done at FB_AW width. Row base is accumulated by +FB_STRIDE per line; there is no multiplier.
//  Reset mid-job: the job is aborted immediately, the buffer is flushed and no done_o is produced.
// CONFIGURATION
//  Macro CAL_LBL_RENDER_INV_EN:
//   Defined: adds input hl_i (1 bit), sampled with start_i. When the latched hl_i=1, wr_data_o = ~lbl_pix_i, which highlights the current day.
//   Undefined: the port is absent and pixels pass through unmodified.
// STRUCTURE
//  Package cal_lable_pkg:
//   state enum {IDLE, SCAN, DRAIN, DONE};
//   typedef wr_beat_t {addr, data};
//   width localparams; imports `CAL_POS_CNT from the calendar draw defines.
//  Sub-module cal_lable_skid: parameterised-depth (RD_LAT+1) FIFO of wr_beat_t with push, pop, empty and count.
//  Top module: FSM, x/y counters, row-base accumulator, delay line and credit logic.
// TESTING
//  1. pos=TUE, fb_base=0, ready=1:
//     - exactly 3960 writes; addresses are y*640+x;
//     - data matches the label model; x=0 and x=131 are 0;
//     - done_o at cycle 3960+RD_LAT+2.
//  2. wr_ready_i toggles randomly at 50%:
//     - no lost or duplicated beats; addresses strictly ascending in raster order;
//     - wr_addr_o and wr_data_o stable while stalled.
//  3. wr_ready_i=0 for 100 cycles mid-line:
//     - issue stops at RD_LAT+1 outstanding;
//     - resumes with no gap and correct data.
//  4. start_i pulsed again during a job with pos=SUN:
//     - ignored; all pixels come from the first pos.
//  5. rst_i asserted at pixel 1000:
//     - all outputs go to 0 asynchronously; no done_o;
//     - next start produces a full, correct job.
//  6. fb_base=2**19-100:
//     - addresses wrap modulo 2**19;
//     - with CAL_LBL_RENDER_INV_EN and hl_i=1, every data bit is inverted.

Source files
------------

// File: rtl/cal_lable_pkg.sv
// -----------------------------------------------------------------------------
// cal_lable_pkg
// Shared types and widths for the calendar day-label renderer.
// CAL_POS_CNT normally comes from the calendar draw defines. The default of 7
// (MON..SUN) below only applies when those defines are not in the build.
// -----------------------------------------------------------------------------
`ifndef CAL_POS_CNT
`define CAL_POS_CNT 7
`endif

package cal_lable_pkg;

  localparam int PIX_X_W = 12;
  localparam int PIX_Y_W = 12;
  localparam int FB_AW   = 19;
  localparam int POS_CNT = `CAL_POS_CNT;
  localparam int POS_W   = $clog2(POS_CNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One frame-buffer write: target address plus the pixel value.
  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic             data;
  } wr_beat_t;

endpackage

// File: rtl/cal_lable_skid.sv
// -----------------------------------------------------------------------------
// cal_lable_skid
// Small FIFO of write beats between the label ROM return path and the
// frame-buffer write port. Depth is sized by the caller so the credit logic
// can never push into a full buffer.
// -----------------------------------------------------------------------------
module cal_lable_skid
  import cal_lable_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  wr_beat_t         push_beat,
  input  logic             pop,
  output wr_beat_t         head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_beat_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Beat storage.
  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // observed while count says it is occupied, and it is always written first.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_beat;
  end

  // Read/write pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/cal_lable_render_ctrl.sv
// -----------------------------------------------------------------------------
// cal_lable_render_ctrl
// Scans a WIN_X x WIN_Y window over one day label, feeds the coordinates to the
// label pixel block and streams the returned pixels to the frame buffer.
// Optional feature macro: CAL_LBL_RENDER_INV_EN adds hl_i; when latched high
// every written pixel is inverted to highlight the current day.
// -----------------------------------------------------------------------------
module cal_lable_render_ctrl
  import cal_lable_pkg::*;
#(
  parameter int WIN_X     = 132,
  parameter int WIN_Y     = 30,
  parameter int RD_LAT    = 1,
  parameter int FB_STRIDE = 640
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [POS_W-1:0]   pos_i,
  input  logic [FB_AW-1:0]   fb_base_i,
`ifdef CAL_LBL_RENDER_INV_EN
  input  logic               hl_i,
`endif
  output logic               busy_o,
  output logic               done_o,
  output logic [POS_W-1:0]   lbl_pos_o,
  output logic [PIX_X_W-1:0] lbl_x_o,
  output logic [PIX_Y_W-1:0] lbl_y_o,
  input  logic               lbl_pix_i,
  output logic               wr_valid_o,
  input  logic               wr_ready_i,
  output logic [FB_AW-1:0]   wr_addr_o,
  output logic               wr_data_o
);

  // Buffer holds every beat that can be outstanding, so a returning pixel
  // always has a slot.
  localparam int DEPTH = RD_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CR_W  = $clog2(2 * DEPTH + 1) + 1;

  state_t           state, state_nxt;
  logic [FB_AW-1:0] row_base;
  logic [FB_AW-1:0] addr_cur;
  logic             hl_in;
  logic             hl_q;
  logic             start_ok;
  logic             x_last;
  logic             last_xy;
  logic             issue;
  logic             pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] occ;
  logic [CR_W-1:0]  in_flight;
  logic             dl_valid [RD_LAT];
  logic [FB_AW-1:0] dl_addr  [RD_LAT];
  wr_beat_t         push_beat;
  wr_beat_t         head_beat;
  wr_beat_t         last_beat;

`ifdef CAL_LBL_RENDER_INV_EN
  assign hl_in = hl_i;
`else
  assign hl_in = 1'b0;
`endif

  assign start_ok = (state == IDLE) && start_i;
  assign x_last   = (lbl_x_o == PIX_X_W'(WIN_X - 1));
  assign last_xy  = x_last && (lbl_y_o == PIX_Y_W'(WIN_Y - 1));
  assign addr_cur = row_base + FB_AW'(lbl_x_o);
  assign pop      = wr_valid_o && wr_ready_i;

  // Count reads still travelling through the ROM delay line.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CR_W'(dl_valid[i]);
  end

  // Credit: a beat leaving the buffer this cycle frees its slot at the same
  // edge, which is what lets a ready-high sink see one write every cycle.
  assign issue = (state == SCAN) &&
                 ((CR_W'(occ) + in_flight) < (CR_W'(DEPTH) + CR_W'(pop)));

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and status outputs.
  // NOTE: every output of this block gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) state_nxt = SCAN;
      end
      SCAN: begin
        busy_o = 1'b1;
        if (issue && last_xy) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (fifo_empty && (in_flight == '0)) state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job latch, raster x/y counters and row-base accumulator.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lbl_x_o   <= '0;
      lbl_y_o   <= '0;
      lbl_pos_o <= '0;
      row_base  <= '0;
      hl_q      <= 1'b0;
    end else if (start_ok) begin
      lbl_x_o   <= '0;
      lbl_y_o   <= '0;
      lbl_pos_o <= pos_i;
      row_base  <= fb_base_i;
      hl_q      <= hl_in;
    end else if (issue && !last_xy) begin
      if (x_last) begin
        lbl_x_o  <= '0;
        lbl_y_o  <= lbl_y_o + 1'b1;
        row_base <= row_base + FB_AW'(FB_STRIDE);
      end else begin
        lbl_x_o <= lbl_x_o + 1'b1;
      end
    end
  end

  // Delay line matching the ROM latency: carries {valid, addr} per read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        dl_valid[i] <= 1'b0;
        dl_addr[i]  <= '0;
      end
    end else begin
      dl_valid[0] <= issue;
      dl_addr[0]  <= addr_cur;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_addr[i]  <= dl_addr[i-1];
      end
    end
  end

  assign push_beat.addr = dl_addr[RD_LAT-1];
  assign push_beat.data = lbl_pix_i ^ hl_q;

  cal_lable_skid #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (dl_valid[RD_LAT-1]),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head_beat),
    .empty     (fifo_empty),
    .count     (occ)
  );

  // Remember the last accepted beat so the write port holds it when idle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)   last_beat <= '0;
    else if (pop) last_beat <= head_beat;
  end

  assign wr_valid_o = !fifo_empty;
  assign wr_addr_o  = fifo_empty ? last_beat.addr : head_beat.addr;
  assign wr_data_o  = fifo_empty ? last_beat.data : head_beat.data;

endmodule

// File: tb/tb_cal_lable_render_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cal_lable_render_ctrl
// Scoreboard bench: each job pushes its full expected write list (computed as
// base + y*stride + x with a bench-side label ROM model) and a negedge monitor
// pops and compares every accepted write.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cal_lable_render_ctrl;
  import cal_lable_pkg::*;

  localparam int WIN_X  = 132;
  localparam int WIN_Y  = 30;
  localparam int RD_LAT = 1;
  localparam int STRIDE = 640;
  localparam int NPIX   = WIN_X * WIN_Y;
  localparam int TUE    = 1;
  localparam int SUN    = 6;
`ifdef CAL_LBL_RENDER_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic               clk        = 1'b0;
  logic               rst_i      = 1'b1;
  logic               start_i    = 1'b0;
  logic [POS_W-1:0]   pos_i      = '0;
  logic [FB_AW-1:0]   fb_base_i  = '0;
`ifdef CAL_LBL_RENDER_INV_EN
  logic               hl_i       = 1'b0;
`endif
  logic               lbl_pix_i  = 1'b0;
  logic               wr_ready_i = 1'b1;
  logic               busy_o, done_o, wr_valid_o, wr_data_o;
  logic [POS_W-1:0]   lbl_pos_o;
  logic [PIX_X_W-1:0] lbl_x_o;
  logic [PIX_Y_W-1:0] lbl_y_o;
  logic [FB_AW-1:0]   wr_addr_o;

  cal_lable_render_ctrl #(
    .WIN_X     (WIN_X),
    .WIN_Y     (WIN_Y),
    .RD_LAT    (RD_LAT),
    .FB_STRIDE (STRIDE)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .pos_i      (pos_i),
    .fb_base_i  (fb_base_i),
`ifdef CAL_LBL_RENDER_INV_EN
    .hl_i       (hl_i),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .lbl_pos_o  (lbl_pos_o),
    .lbl_x_o    (lbl_x_o),
    .lbl_y_o    (lbl_y_o),
    .lbl_pix_i  (lbl_pix_i),
    .wr_valid_o (wr_valid_o),
    .wr_ready_i (wr_ready_i),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o)
  );

  always #5 clk = ~clk;

  wr_beat_t         exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               start_cyc = 0;
  int               wr_cnt = 0;
  int               done_cnt = 0;
  int               ready_mode = 0;
  bit               stall_armed = 1'b0;
  int               stall_hits = 0;
  logic             prev_stall = 1'b0;
  logic [FB_AW-1:0] prev_addr = '0;
  logic             prev_data = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Label glyph model: blank left offset column and right border column,
  // an arbitrary per-label bit pattern in between.
  function automatic logic label_pix(input int pos, input int x, input int y);
    int h;
    if (x <= 0 || x >= WIN_X - 1) return 1'b0;
    h = (x * 37 + y * 101 + pos * 59) ^ (x * y);
    return h[3];
  endfunction

  // Label pixel ROM with one cycle of read latency.
  initial forever begin
    @(posedge clk);
    lbl_pix_i <= label_pix(int'(lbl_pos_o), int'(lbl_x_o), int'(lbl_y_o));
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares accepted writes and checks hold-while-stalled.
  initial forever begin
    wr_beat_t e;
    @(negedge clk);
    if (!rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", wr_valid_o, 1);
        check("stall_addr_held", wr_addr_o, prev_addr);
        check("stall_data_held", wr_data_o, prev_data);
      end
      if (wr_valid_o && wr_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got addr 0x%0h, expected no write", wr_addr_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr_o, e.addr);
          check("wr_data", wr_data_o, e.data);
        end
        wr_cnt++;
      end
      if (done_o) done_cnt++;
      prev_stall = wr_valid_o && !wr_ready_i;
      prev_addr  = wr_addr_o;
      prev_data  = wr_data_o;
    end
  end

  // Ready driver: always-ready, 50% random, or a 100-cycle mid-line stall.
  initial begin
    int g;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        wr_ready_i = 1'($urandom_range(0, 1));
      end else if (ready_mode == 2 && stall_armed && wr_cnt >= 50) begin
        stall_armed = 1'b0;
        wr_ready_i  = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("outstanding_at_stall",
              int'(lbl_y_o) * WIN_X + int'(lbl_x_o) - wr_cnt, RD_LAT + 1);
        check("valid_during_stall", wr_valid_o, 1);
        wr_ready_i = 1'b1;
        g = 0;
        repeat (20) begin
          @(negedge clk);
          if (wr_valid_o) g++;
        end
        check("resume_no_gap", g, 20);
        stall_hits++;
      end else begin
        wr_ready_i = 1'b1;
      end
    end
  end

  task automatic start_job(input int pos, input int base, input logic hl);
    wr_beat_t b;
    @(posedge clk);
    #1;
    exp_q.delete();
    for (int y = 0; y < WIN_Y; y++) begin
      for (int x = 0; x < WIN_X; x++) begin
        b.addr = FB_AW'(base + y * STRIDE + x);
        b.data = label_pix(pos, x, y) ^ (hl & INV_EN);
        exp_q.push_back(b);
      end
    end
    start_i   = 1'b1;
    pos_i     = POS_W'(pos);
    fb_base_i = FB_AW'(base);
`ifdef CAL_LBL_RENDER_INV_EN
    hl_i      = hl;
`endif
    wr_cnt    = 0;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start_i   = 1'b0;
    pos_i     = POS_W'($urandom_range(0, 6));
    fb_base_i = FB_AW'($urandom);
`ifdef CAL_LBL_RENDER_INV_EN
    hl_i      = ~hl;
`endif
    check("busy_after_start", busy_o, 1);
    check("pos_latched", lbl_pos_o, pos);
  endtask

  task automatic wait_done(input bit chk_time);
    bit seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done_o) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (chk_time) check("done_cycle", cyc - start_cyc, NPIX + RD_LAT + 2);
    check("write_count", wr_cnt, NPIX);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_low_at_done", busy_o, 0);
    @(posedge clk);
    #1;
    check("done_single_cycle", done_o, 0);
  endtask

  initial begin
    int d0;
    bit hit;
    #2 rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_wr_valid", wr_valid_o, 0);
    check("rst_lbl_x", lbl_x_o, 0);
    check("rst_lbl_y", lbl_y_o, 0);
    check("rst_lbl_pos", lbl_pos_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    rst_i = 1'b1;

    // Zero-bubble job at base 0.
    ready_mode = 0;
    start_job(TUE, 0, 1'b0);
    wait_done(1'b1);

    // Random 50% back-pressure.
    ready_mode = 1;
    start_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 200000)), 1'b0);
    wait_done(1'b0);

    // Long mid-line stall.
    ready_mode  = 2;
    stall_armed = 1'b1;
    start_job(3, 1000, 1'b0);
    wait_done(1'b0);
    check("stall_exercised", stall_hits, 1);

    // Second start during a job must be ignored.
    ready_mode = 0;
    start_job(TUE, 5000, 1'b0);
    repeat (500) @(posedge clk);
    #1;
    start_i   = 1'b1;
    pos_i     = POS_W'(SUN);
    fb_base_i = FB_AW'(12345);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("pos_held_after_restart", lbl_pos_o, TUE);
    check("busy_held_after_restart", busy_o, 1);
    wait_done(1'b1);

    // Reset mid-job, then a clean job.
    start_job(2, 777, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 5000 && !hit; k++) begin
      @(posedge clk);
      #1;
      if (wr_cnt >= 1000) hit = 1'b1;
    end
    check("reached_pixel_1000", hit, 1);
    @(negedge clk);
    #2;
    d0 = done_cnt;
    rst_i = 1'b0;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_wr_valid", wr_valid_o, 0);
    check("abort_lbl_x", lbl_x_o, 0);
    check("abort_lbl_y", lbl_y_o, 0);
    check("abort_lbl_pos", lbl_pos_o, 0);
    check("abort_wr_addr", wr_addr_o, 0);
    check("abort_wr_data", wr_data_o, 0);
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    rst_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt, d0);
    check("idle_after_abort", busy_o, 0);
    start_job(5, 3210, 1'b0);
    wait_done(1'b1);

    // Address wrap near the top of the frame buffer, highlighted if enabled.
    start_job(int'($urandom_range(0, 6)), (1 << FB_AW) - 100, 1'b1);
    wait_done(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
